// File: rtl/keypoint_reader_if.sv
// Keypoint output stream: valid/ready handshake carrying one keypoint per beat.
// The reader drives the master side; the downstream consumer drives the slave side.
interface keypoint_reader_if;
  logic       kp_valid;
  logic       kp_ready;
  logic [8:0] kp_row;
  logic [9:0] kp_col;
  logic       kp_layer;
  logic       kp_last;

  modport master (
    output kp_valid,
    output kp_row,
    output kp_col,
    output kp_layer,
    output kp_last,
    input  kp_ready
  );

  modport slave (
    input  kp_valid,
    input  kp_row,
    input  kp_col,
    input  kp_layer,
    input  kp_last,
    output kp_ready
  );
endinterface

// File: rtl/keypoint_reader.sv
// Streams keypoints out of two single-cycle-latency SRAMs, layer 1 first, then layer 2.
// Each keypoint costs FETCH (address), LOAD (capture dout) and OUT (handshake).
module keypoint_reader (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_start,
  input  logic [11:0]                i_kp1_count,
  input  logic [11:0]                i_kp2_count,
  output logic [10:0]                o_keypoint_1_addr,
  input  logic [18:0]                i_keypoint_1_dout,
  output logic [10:0]                o_keypoint_2_addr,
  input  logic [18:0]                i_keypoint_2_dout,
  keypoint_reader_if.master          kp_if,
  output logic                       o_busy,
  output logic                       o_done
);

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StOut, StFin} state_e;

  state_e      r_state;
  logic [11:0] r_index;
  logic        r_layer;
  logic [11:0] r_cnt1;
  logic [11:0] r_cnt2;
  logic [10:0] r_addr1;
  logic [10:0] r_addr2;
  logic        r_valid;
  logic [8:0]  r_row;
  logic [9:0]  r_col;
  logic        r_kp_layer;
  logic        r_last;
  logic        r_busy;
  logic        r_done;

  logic [11:0] w_sat1;
  logic [11:0] w_sat2;
  logic [11:0] w_cur_cnt;
  logic [11:0] w_next_idx;
  logic [18:0] w_dout;
  logic        w_last;

  assign w_sat1     = (i_kp1_count > 12'd2048) ? 12'd2048 : i_kp1_count;
  assign w_sat2     = (i_kp2_count > 12'd2048) ? 12'd2048 : i_kp2_count;
  assign w_cur_cnt  = r_layer ? r_cnt2 : r_cnt1;
  assign w_next_idx = r_index + 12'd1;
  assign w_dout     = r_layer ? i_keypoint_2_dout : i_keypoint_1_dout;
  // Layer-1 tail is only final when layer 2 has nothing to contribute.
  assign w_last     = (r_layer && (w_next_idx == r_cnt2)) ||
                      (!r_layer && (w_next_idx == r_cnt1) && (r_cnt2 == 12'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_index    <= 12'd0;
      r_layer    <= 1'b0;
      r_cnt1     <= 12'd0;
      r_cnt2     <= 12'd0;
      r_addr1    <= 11'd0;
      r_addr2    <= 11'd0;
      r_valid    <= 1'b0;
      r_row      <= 9'd0;
      r_col      <= 10'd0;
      r_kp_layer <= 1'b0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_cnt1  <= w_sat1;
            r_cnt2  <= w_sat2;
            r_index <= 12'd0;
            if ((w_sat1 == 12'd0) && (w_sat2 == 12'd0)) begin
              r_layer <= 1'b0;
              r_done  <= 1'b1;
              r_state <= StFin;
            end else if (w_sat1 == 12'd0) begin
              r_layer <= 1'b1;
              r_addr2 <= 11'd0;
              r_busy  <= 1'b1;
              r_state <= StFetch;
            end else begin
              r_layer <= 1'b0;
              r_addr1 <= 11'd0;
              r_busy  <= 1'b1;
              r_state <= StFetch;
            end
          end
        end
        // Address was placed on the bus when entering FETCH; dout arrives next cycle.
        StFetch: r_state <= StLoad;
        StLoad: begin
          r_row      <= w_dout[18:10];
          r_col      <= w_dout[9:0];
          r_kp_layer <= r_layer;
          r_last     <= w_last;
          r_valid    <= 1'b1;
          r_state    <= StOut;
        end
        StOut: begin
          if (kp_if.kp_ready) begin
            r_valid <= 1'b0;
            if (w_next_idx < w_cur_cnt) begin
              r_index <= w_next_idx;
              if (r_layer) r_addr2 <= w_next_idx[10:0];
              else         r_addr1 <= w_next_idx[10:0];
              r_state <= StFetch;
            end else if (!r_layer && (r_cnt2 != 12'd0)) begin
              r_layer <= 1'b1;
              r_index <= 12'd0;
              r_addr2 <= 11'd0;
              r_state <= StFetch;
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= StFin;
            end
          end
        end
        StFin:   r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_keypoint_1_addr = r_addr1;
  assign o_keypoint_2_addr = r_addr2;
  assign kp_if.kp_valid    = r_valid;
  assign kp_if.kp_row      = r_row;
  assign kp_if.kp_col      = r_col;
  assign kp_if.kp_layer    = r_kp_layer;
  assign kp_if.kp_last     = r_last;
  assign o_busy            = r_busy;
  assign o_done            = r_done;

endmodule

// File: tb/tb_keypoint_reader.sv
// Directed bench for keypoint_reader: SRAM models, scoreboard of expected keypoints,
// and a negedge monitor that pops and compares on every handshake.
module tb_keypoint_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] kp1_count = 12'd0;
  logic [11:0] kp2_count = 12'd0;
  logic [10:0] addr1;
  logic [10:0] addr2;
  logic [18:0] dout1 = 19'd0;
  logic [18:0] dout2 = 19'd0;
  logic        busy;
  logic        done;

  logic [18:0] mem1 [0:2047];
  logic [18:0] mem2 [0:2047];

  keypoint_reader_if kp_bus ();

  keypoint_reader dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_start           (start),
    .i_kp1_count       (kp1_count),
    .i_kp2_count       (kp2_count),
    .o_keypoint_1_addr (addr1),
    .i_keypoint_1_dout (dout1),
    .o_keypoint_2_addr (addr2),
    .i_keypoint_2_dout (dout2),
    .kp_if             (kp_bus),
    .o_busy            (busy),
    .o_done            (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    dout1 <= mem1[addr1];
    dout2 <= mem2[addr2];
  end

  typedef struct packed {
    logic [18:0] data;
    logic        layer;
    logic        last;
    logic [10:0] addr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_hs = 0;
  int   n_valid_cycles = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && kp_bus.kp_valid) begin
      n_valid_cycles++;
      if (kp_bus.kp_ready) begin
        n_hs++;
        check("sb_has_entry", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check("kp_row", kp_bus.kp_row, mon_e.data[18:10]);
          check("kp_col", kp_bus.kp_col, mon_e.data[9:0]);
          check("kp_layer", kp_bus.kp_layer, mon_e.layer);
          check("kp_last", kp_bus.kp_last, mon_e.last);
          check("kp_addr", mon_e.layer ? addr2 : addr1, mon_e.addr);
        end
      end
    end
  end

  task automatic push_exp(input int c1, input int c2);
    int n1;
    int n2;
    n1 = (c1 > 2048) ? 2048 : c1;
    n2 = (c2 > 2048) ? 2048 : c2;
    for (int i = 0; i < n1; i++)
      sb_q.push_back('{data: mem1[i], layer: 1'b0, last: (i == n1 - 1) && (n2 == 0),
                       addr: 11'(i)});
    for (int i = 0; i < n2; i++)
      sb_q.push_back('{data: mem2[i], layer: 1'b1, last: (i == n2 - 1), addr: 11'(i)});
  endtask

  // Returns with start low, one tick after the edge that accepts it.
  task automatic run_start(input int c1, input int c2);
    push_exp(c1, c2);
    @(posedge clk); #1;
    start = 1'b1;
    kp1_count = 12'(c1);
    kp2_count = 12'(c2);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat, output logic seen);
    lat = 0;
    seen = done;
    while (!seen && lat < budget) begin
      @(posedge clk); #1;
      lat++;
      seen = done;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, kp_bus.kp_valid, 0);
    check({tag, "_row"}, kp_bus.kp_row, 0);
    check({tag, "_col"}, kp_bus.kp_col, 0);
    check({tag, "_layer"}, kp_bus.kp_layer, 0);
    check({tag, "_last"}, kp_bus.kp_last, 0);
    check({tag, "_addr1"}, addr1, 0);
    check({tag, "_addr2"}, addr2, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic seen;
    int   hs0;
    int   v0;
    int   cnt;

    for (int i = 0; i < 2048; i++) begin
      mem1[i] = 19'd0;
      mem2[i] = 19'd0;
    end
    mem1[0] = {9'd5, 10'd10};
    mem1[1] = {9'd6, 10'd20};
    mem1[2] = {9'd7, 10'd30};
    mem2[0] = {9'd8, 10'd40};
    mem2[1] = {9'd9, 10'd50};
    kp_bus.kp_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Normal readout 3 + 2
    hs0 = n_hs;
    run_start(3, 2);
    check("normal_busy", busy, 1);
    wait_done(100, lat, seen);
    check("normal_done_seen", seen, 1);
    check("normal_done_latency", lat, 15);
    check("normal_busy_in_fin", busy, 0);
    check("normal_hs_count", n_hs - hs0, 5);
    check("normal_sb_empty", sb_q.size(), 0);
    @(posedge clk); #1;
    check("normal_done_width", done, 0);

    // Empty readout
    v0 = n_valid_cycles;
    run_start(0, 0);
    wait_done(5, lat, seen);
    check("empty_done_seen", seen, 1);
    check("empty_done_latency", lat, 0);
    check("empty_busy", busy, 0);
    @(posedge clk); #1;
    check("empty_done_width", done, 0);
    check("empty_no_valid", n_valid_cycles - v0, 0);

    // Backpressure on the first keypoint of a layer-1-only readout
    kp_bus.kp_ready = 1'b0;
    hs0 = n_hs;
    run_start(3, 0);
    cnt = 0;
    while (!kp_bus.kp_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("bp_valid_seen", kp_bus.kp_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_valid_hold", kp_bus.kp_valid, 1);
      check("bp_row_hold", kp_bus.kp_row, 9'd5);
      check("bp_col_hold", kp_bus.kp_col, 10'd10);
      check("bp_addr_hold", addr1, 0);
    end
    kp_bus.kp_ready = 1'b1;
    wait_done(50, lat, seen);
    check("bp_done_seen", seen, 1);
    check("bp_hs_count", n_hs - hs0, 3);
    check("bp_sb_empty", sb_q.size(), 0);

    // Layer 1 empty: addr1 keeps the last value from the previous readout
    hs0 = n_hs;
    run_start(0, 1);
    wait_done(20, lat, seen);
    check("l1e_done_seen", seen, 1);
    check("l1e_done_latency", lat, 3);
    check("l1e_addr1_held", addr1, 2);
    check("l1e_hs_count", n_hs - hs0, 1);
    check("l1e_sb_empty", sb_q.size(), 0);

    // Reset during the second OUT
    run_start(3, 2);
    cnt = 0;
    for (int i = 0; i < 30 && cnt < 2; i++) begin
      @(posedge clk); #1;
      if (kp_bus.kp_valid) cnt++;
    end
    check("rst_second_out", cnt, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    sb_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("midrst_no_done", done, 0);
    end
    rst_n = 1'b1;
    hs0 = n_hs;
    run_start(1, 0);
    wait_done(20, lat, seen);
    check("restart_done_seen", seen, 1);
    check("restart_done_latency", lat, 3);
    check("restart_hs_count", n_hs - hs0, 1);
    check("restart_sb_empty", sb_q.size(), 0);

    // Saturation: 4095 requested, 2048 delivered; a start while busy is ignored
    for (int i = 0; i < 2048; i++) mem1[i] = {9'(i * 3 + 1), 10'(i)};
    hs0 = n_hs;
    run_start(4095, 0);
    repeat (100) @(posedge clk);
    #1;
    start = 1'b1;
    kp1_count = 12'd1;
    kp2_count = 12'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(7000, lat, seen);
    check("sat_done_seen", seen, 1);
    check("sat_hs_count", n_hs - hs0, 2048);
    check("sat_sb_empty", sb_q.size(), 0);
    check("sat_final_addr", addr1, 11'd2047);
    v0 = n_valid_cycles;
    repeat (10) @(posedge clk);
    #1;
    check("sat_idle_after", busy, 0);
    check("sat_no_extra_valid", n_valid_cycles - v0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
